// File: rtl/uart_rx_core.sv
// UART receiver: NCO tick generator (16 ticks/bit), majority-vote bit sampling,
// frame FSM and a first-word-fall-through receive FIFO.
module uart_rx_core #(
  parameter int DATA_W     = 9,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rxd,
  input  logic [15:0]       cfg_inc,
  input  logic [3:0]        cfg_bits,
  input  logic [1:0]        cfg_parity,
  input  logic              cfg_stop,
  output logic [DATA_W-1:0] m_data,
  output logic              m_perr,
  output logic              m_ferr,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              overrun,
  output logic              brk,
  output logic              busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int EW = DATA_W + 2;

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_COMMIT, S_WAIT_IDLE
  } state_t;

  state_t            state_q, state_d;
  logic [15:0]       acc_q, acc_d;
  logic [1:0]        sync_q, sync_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              s7_q, s7_d, s8_q, s8_d;
  logic [3:0]        bits_q, bits_d;
  logic [1:0]        pmode_q, pmode_d;
  logic              stop2_q, stop2_d;
  logic [3:0]        idx_q, idx_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              par_q, par_d, parbit_q, parbit_d;
  logic              perr_q, perr_d, ferr_q, ferr_d;
  logic              brk_q, brk_d, ovr_q, ovr_d, busy_q, busy_d;
  logic [AW:0]       wr_q, wr_d, rd_q, rd_d;
  logic [EW-1:0]     mem_q [FIFO_DEPTH];

  logic [16:0]       acc_sum;
  logic              tick, rxs, maj, decide, par_en;
  logic [3:0]        bits_clamp;
  logic              push, pop, empty, full, wr_en;
  logic [EW-1:0]     head;

  assign acc_sum = {1'b0, acc_q} + {1'b0, cfg_inc};
  assign tick    = acc_sum[16];
  assign rxs     = sync_q[1];
  assign maj     = (s7_q & s8_q) | (s7_q & rxs) | (s8_q & rxs);
  assign decide  = tick && (cnt_q == 4'd9);
  assign par_en  = (pmode_q == 2'b01) || (pmode_q == 2'b10);

  always_comb begin
    if (cfg_bits < 4'd5)                bits_clamp = 4'd5;
    else if (cfg_bits > 4'(DATA_W))     bits_clamp = 4'(DATA_W);
    else                                bits_clamp = cfg_bits;
  end

  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign pop   = !empty && m_ready;
  assign wr_en = push && (!full || pop);

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_sum[15:0];
    sync_d   = {sync_q[0], rxd};
    cnt_d    = cnt_q;
    s7_d     = s7_q;
    s8_d     = s8_q;
    bits_d   = bits_q;
    pmode_d  = pmode_q;
    stop2_d  = stop2_q;
    idx_d    = idx_q;
    data_d   = data_q;
    par_d    = par_q;
    parbit_d = parbit_q;
    perr_d   = perr_q;
    ferr_d   = ferr_q;
    brk_d    = 1'b0;
    push     = 1'b0;

    // Bit-sampling states share one free-running 0..15 tick counter.
    if (tick && (state_q == S_START || state_q == S_DATA ||
                 state_q == S_PARITY || state_q == S_STOP)) begin
      cnt_d = cnt_q + 4'd1;
      if (cnt_q == 4'd7) s7_d = rxs;
      if (cnt_q == 4'd8) s8_d = rxs;
    end

    case (state_q)
      S_IDLE: begin
        if (tick && !rxs) begin
          state_d  = S_START;
          cnt_d    = 4'd0;
          bits_d   = bits_clamp;
          pmode_d  = cfg_parity;
          stop2_d  = cfg_stop;
          idx_d    = 4'd0;
          data_d   = '0;
          par_d    = 1'b0;
          parbit_d = 1'b0;
          perr_d   = 1'b0;
          ferr_d   = 1'b0;
        end
      end
      S_START: if (decide) state_d = maj ? S_IDLE : S_DATA;
      S_DATA: begin
        if (decide) begin
          data_d[idx_q] = maj;
          par_d         = par_q ^ maj;
          if (idx_q == bits_q - 4'd1) begin
            idx_d   = 4'd0;
            state_d = par_en ? S_PARITY : S_STOP;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end
      S_PARITY: begin
        if (decide) begin
          parbit_d = maj;
          perr_d   = (pmode_q == 2'b10) ? ~(par_q ^ maj) : (par_q ^ maj);
          state_d  = S_STOP;
        end
      end
      S_STOP: begin
        if (decide) begin
          // A low stop bit ends the frame immediately.
          if (!maj || idx_q == {3'b000, stop2_q}) begin
            ferr_d  = !maj;
            brk_d   = (data_q == '0) && (!par_en || !parbit_q) && !maj;
            state_d = S_COMMIT;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end
      S_COMMIT: begin
        push    = 1'b1;
        cnt_d   = 4'd0;
        state_d = ferr_q ? S_WAIT_IDLE : S_IDLE;
      end
      S_WAIT_IDLE: begin
        if (tick) begin
          if (!rxs)                cnt_d = 4'd0;
          else if (cnt_q == 4'd15) state_d = S_IDLE;
          else                     cnt_d = cnt_q + 4'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
    ovr_d  = push && full && !pop;
    wr_d   = wr_q + {{AW{1'b0}}, wr_en};
    rd_d   = rd_q + {{AW{1'b0}}, pop};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      acc_q    <= '0;
      sync_q   <= 2'b11;
      cnt_q    <= '0;
      s7_q     <= 1'b1;
      s8_q     <= 1'b1;
      bits_q   <= 4'd8;
      pmode_q  <= 2'b00;
      stop2_q  <= 1'b0;
      idx_q    <= '0;
      data_q   <= '0;
      par_q    <= 1'b0;
      parbit_q <= 1'b0;
      perr_q   <= 1'b0;
      ferr_q   <= 1'b0;
      brk_q    <= 1'b0;
      ovr_q    <= 1'b0;
      busy_q   <= 1'b0;
      wr_q     <= '0;
      rd_q     <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      sync_q   <= sync_d;
      cnt_q    <= cnt_d;
      s7_q     <= s7_d;
      s8_q     <= s8_d;
      bits_q   <= bits_d;
      pmode_q  <= pmode_d;
      stop2_q  <= stop2_d;
      idx_q    <= idx_d;
      data_q   <= data_d;
      par_q    <= par_d;
      parbit_q <= parbit_d;
      perr_q   <= perr_d;
      ferr_q   <= ferr_d;
      brk_q    <= brk_d;
      ovr_q    <= ovr_d;
      busy_q   <= busy_d;
      wr_q     <= wr_d;
      rd_q     <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_q[AW-1:0]] <= {data_q, perr_q, ferr_q};
  end

  // Head is masked while empty so outputs read 0 out of reset.
  assign head    = mem_q[rd_q[AW-1:0]];
  assign m_valid = !empty;
  assign m_data  = empty ? '0 : head[EW-1:2];
  assign m_perr  = empty ? 1'b0 : head[1];
  assign m_ferr  = empty ? 1'b0 : head[0];
  assign overrun = ovr_q;
  assign brk     = brk_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed bench for uart_rx_core: serial frames driven bit by bit, popped
// words and status pulses collected by a monitor and checked per scenario.
`timescale 1ns/1ps
module tb_uart_rx_core;
  localparam int DATA_W     = 9;
  localparam int FIFO_DEPTH = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              rxd = 1'b1;
  logic [15:0]       cfg_inc = 16'd8192;
  logic [3:0]        cfg_bits = 4'd8;
  logic [1:0]        cfg_parity = 2'b00;
  logic              cfg_stop = 1'b0;
  logic [DATA_W-1:0] m_data;
  logic              m_perr, m_ferr, m_valid;
  logic              m_ready = 1'b1;
  logic              overrun, brk, busy;

  uart_rx_core #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .rxd(rxd),
    .cfg_inc(cfg_inc), .cfg_bits(cfg_bits), .cfg_parity(cfg_parity), .cfg_stop(cfg_stop),
    .m_data(m_data), .m_perr(m_perr), .m_ferr(m_ferr), .m_valid(m_valid), .m_ready(m_ready),
    .overrun(overrun), .brk(brk), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int bitc  = 128;
  int brk_cnt = 0;
  int ovr_cnt = 0;
  logic [DATA_W+1:0] rx_q[$];

  always @(negedge clk) begin
    if (rst_n) begin
      if (m_valid && m_ready) rx_q.push_back({m_data, m_perr, m_ferr});
      if (brk) brk_cnt++;
      if (overrun) ovr_cnt++;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [8:0] d, input int nbits, input bit use_par,
                            input logic pbit, input int nstop);
    rxd = 1'b0; cyc(bitc);
    for (int i = 0; i < nbits; i++) begin rxd = d[i]; cyc(bitc); end
    if (use_par) begin rxd = pbit; cyc(bitc); end
    for (int i = 0; i < nstop; i++) begin rxd = 1'b1; cyc(bitc); end
    rxd = 1'b1;
  endtask

  task automatic check_word(input string name, input int idx, input logic [DATA_W+1:0] exp);
    logic [DATA_W+1:0] got;
    got = (rx_q.size() > idx) ? rx_q[idx] : 'x;
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got {data,perr,ferr}=%h want %h", name, got, exp);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rxd = 1'b1; cyc(3);
    n_cmp++; if (m_valid !== 1'b0) begin n_err++; $display("FAIL rst_m_valid: got %b want 0", m_valid); end
    n_cmp++; if (m_data !== '0) begin n_err++; $display("FAIL rst_m_data: got %h want 000", m_data); end
    n_cmp++; if (m_perr !== 1'b0) begin n_err++; $display("FAIL rst_m_perr: got %b want 0", m_perr); end
    n_cmp++; if (m_ferr !== 1'b0) begin n_err++; $display("FAIL rst_m_ferr: got %b want 0", m_ferr); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b want 0", busy); end
    n_cmp++; if (brk !== 1'b0) begin n_err++; $display("FAIL rst_brk: got %b want 0", brk); end
    n_cmp++; if (overrun !== 1'b0) begin n_err++; $display("FAIL rst_overrun: got %b want 0", overrun); end
    rst_n = 1'b1; cyc(20);
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL idle_busy: got %b want 0", busy); end
  endtask

  task automatic test_nominal();
    cfg_inc = 16'd1208; bitc = 868;
    cfg_bits = 4'd8; cfg_parity = 2'b00; cfg_stop = 1'b0; m_ready = 1'b1;
    rx_q.delete();
    send_frame(9'h0A5, 8, 0, 1'b0, 1);
    cyc(100);
    n_cmp++; if (rx_q.size() != 1) begin n_err++; $display("FAIL nominal_count: got %0d words want 1", rx_q.size()); end
    check_word("nominal_a5", 0, {9'h0A5, 1'b0, 1'b0});
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL nominal_busy: got %b want 0", busy); end
    cfg_inc = 16'd8192; bitc = 128;
    cyc(20);
  endtask

  task automatic test_parity();
    m_ready = 1'b1;
    rx_q.delete();
    cfg_bits = 4'd7; cfg_parity = 2'b10; cfg_stop = 1'b1;
    send_frame(9'h035, 7, 1, 1'b0, 2);
    send_frame(9'h035, 7, 1, 1'b1, 2);
    cfg_bits = 4'd8; cfg_parity = 2'b01; cfg_stop = 1'b0;
    send_frame(9'h003, 8, 1, 1'b0, 1);
    send_frame(9'h003, 8, 1, 1'b1, 1);
    cyc(40);
    check_word("odd_bad_par", 0, {9'h035, 1'b1, 1'b0});
    check_word("odd_good_par", 1, {9'h035, 1'b0, 1'b0});
    check_word("even_good_par", 2, {9'h003, 1'b0, 1'b0});
    check_word("even_bad_par", 3, {9'h003, 1'b1, 1'b0});
  endtask

  task automatic test_bits_clamp();
    m_ready = 1'b1;
    rx_q.delete();
    cfg_bits = 4'd15; cfg_parity = 2'b11; cfg_stop = 1'b0;
    send_frame(9'h1A5, 9, 0, 1'b0, 1);
    cfg_bits = 4'd2;
    send_frame(9'h015, 5, 0, 1'b0, 1);
    cyc(40);
    check_word("clamp_high_9b", 0, {9'h1A5, 1'b0, 1'b0});
    check_word("clamp_low_5b", 1, {9'h015, 1'b0, 1'b0});
    cfg_bits = 4'd8; cfg_parity = 2'b00;
  endtask

  task automatic test_break();
    int b0;
    m_ready = 1'b1;
    rx_q.delete();
    b0 = brk_cnt;
    rxd = 1'b0; cyc(12 * bitc);
    n_cmp++; if (brk_cnt - b0 != 1) begin n_err++; $display("FAIL break_pulses: got %0d want 1", brk_cnt - b0); end
    check_word("break_word", 0, {9'h000, 1'b0, 1'b1});
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL break_busy_low: got %b want 1", busy); end
    rxd = 1'b1; cyc(60);
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL break_busy_wait: got %b want 1", busy); end
    cyc(100);
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL break_busy_idle: got %b want 0", busy); end
    n_cmp++; if (rx_q.size() != 1) begin n_err++; $display("FAIL break_count: got %0d words want 1", rx_q.size()); end
  endtask

  task automatic test_glitch();
    m_ready = 1'b1;
    rx_q.delete();
    rxd = 1'b0; cyc(32);
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL glitch_detect: got busy %b want 1", busy); end
    rxd = 1'b1; cyc(3 * bitc);
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL glitch_busy: got %b want 0", busy); end
    n_cmp++; if (m_valid !== 1'b0) begin n_err++; $display("FAIL glitch_valid: got %b want 0", m_valid); end
    n_cmp++; if (rx_q.size() != 0) begin n_err++; $display("FAIL glitch_count: got %0d words want 0", rx_q.size()); end
  endtask

  task automatic test_overrun();
    int o0;
    m_ready = 1'b0;
    rx_q.delete();
    o0 = ovr_cnt;
    for (int k = 1; k <= FIFO_DEPTH + 1; k++) send_frame(9'(k), 8, 0, 1'b0, 1);
    cyc(20);
    n_cmp++; if (ovr_cnt - o0 != 1) begin n_err++; $display("FAIL overrun_pulses: got %0d want 1", ovr_cnt - o0); end
    n_cmp++; if (m_valid !== 1'b1) begin n_err++; $display("FAIL overrun_valid: got %b want 1", m_valid); end
    n_cmp++; if (m_data !== 9'h001) begin n_err++; $display("FAIL overrun_head_hold: got %h want 001", m_data); end
    m_ready = 1'b1; cyc(10);
    n_cmp++; if (rx_q.size() != FIFO_DEPTH) begin n_err++; $display("FAIL drain_count: got %0d want %0d", rx_q.size(), FIFO_DEPTH); end
    for (int k = 0; k < FIFO_DEPTH; k++) check_word("drain_order", k, {9'(k + 1), 1'b0, 1'b0});
    n_cmp++; if (m_valid !== 1'b0) begin n_err++; $display("FAIL drain_empty: got %b want 0", m_valid); end
  endtask

  task automatic test_reset_midframe();
    logic [8:0] d;
    m_ready = 1'b0;
    send_frame(9'h011, 8, 0, 1'b0, 1);
    cyc(10);
    n_cmp++; if (m_valid !== 1'b1) begin n_err++; $display("FAIL pre_reset_valid: got %b want 1", m_valid); end
    d = 9'h03C;
    rxd = 1'b0; cyc(bitc);
    for (int i = 0; i < 3; i++) begin rxd = d[i]; cyc(bitc); end
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL midframe_busy: got %b want 1", busy); end
    rst_n = 1'b0; rxd = 1'b1; cyc(3);
    n_cmp++; if (m_valid !== 1'b0) begin n_err++; $display("FAIL reset_flush: got %b want 0", m_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    rst_n = 1'b1; cyc(bitc);
    n_cmp++; if (m_valid !== 1'b0) begin n_err++; $display("FAIL post_reset_valid: got %b want 0", m_valid); end
    m_ready = 1'b1;
    rx_q.delete();
    send_frame(9'h05A, 8, 0, 1'b0, 1);
    cyc(40);
    n_cmp++; if (rx_q.size() != 1) begin n_err++; $display("FAIL post_reset_count: got %0d want 1", rx_q.size()); end
    check_word("post_reset_5a", 0, {9'h05A, 1'b0, 1'b0});
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_parity();
    test_bits_clamp();
    test_break();
    test_glitch();
    test_overrun();
    test_reset_midframe();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/uart_rx_core.md
UART_RX_CORE -- requirements
Module: uart_rx_core

Interface
REQ-001 The block SHALL have parameter DATA_W, default 9, meaning the maximum data bits per frame (legal range 5..9).
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 4, meaning the receive FIFO depth in words (power of two, 2..16).
REQ-003 The block SHALL use clk, an input of width 1, as the single clock for all logic.
REQ-004 The block SHALL use rst_n, an input of width 1, as its reset: asynchronous, active-low; clock clk.
REQ-005 The block SHALL have rxd, an input of width 1: serial line, asynchronous to clk, idle high.
REQ-006 The block SHALL have cfg_inc, an input of width 16: NCO increment = round(16 * baud * 2^16 / f_clk).
REQ-007 The block SHALL have cfg_bits, an input of width 4: data bits per frame, 5..DATA_W; values outside the range are clamped to that range.
REQ-008 The block SHALL have cfg_parity, an input of width 2: 00 none, 01 even, 10 odd, 11 none.
REQ-009 The block SHALL have cfg_stop, an input of width 1: 0 = one stop bit, 1 = two stop bits.
REQ-010 The block SHALL have the following output data and handshake signals:
- m_data, an output of width DATA_W: received word, LSB first, right-justified, unused upper bits 0.
- m_perr, an output of width 1: parity error flag for the word at the head of the FIFO.
- m_ferr, an output of width 1: framing error flag for the word at the head of the FIFO.
- m_valid, an output of width 1: the FIFO holds at least one word.
- m_ready, an input of width 1: the consumer accepts the head word.
REQ-011 The block SHALL have the following status outputs, each of width 1:
- overrun: one-cycle pulse when a completed frame is dropped.
- brk: one-cycle pulse when a break is detected.
- busy: high in every state except IDLE.

Function
REQ-012 The tick generator SHALL use a 16-bit phase accumulator that adds cfg_inc every clk; the carry out produces a one-cycle tick, giving 16 ticks per bit. When cfg_inc = 0 there SHALL be no ticks and the FSM SHALL remain in its current state.
REQ-013 rxd SHALL pass through a 2-flop synchroniser whose flops reset to 1. Bit value = majority of the synchronised rxd sampled at ticks 7, 8 and 9 of each bit; the bit is decided at tick 9.
REQ-014 The FSM SHALL have the states IDLE, START, DATA, PARITY, STOP, COMMIT and WAIT_IDLE.
REQ-015 In IDLE, a synchronised-rxd low seen on a tick SHALL move the FSM to START, clear the tick counter, and latch cfg_bits, cfg_parity and cfg_stop for the whole frame.
REQ-016 In START, a majority of 1 SHALL return the FSM to IDLE (glitch rejection) with no outputs affected; a majority of 0 SHALL move it to DATA.
REQ-017 In DATA, the block SHALL shift in the latched bit count, LSB first, and accumulate XOR parity; after the last bit it SHALL go to PARITY if parity is enabled, otherwise to STOP.
REQ-018 In PARITY:
- Even mode: perr = XOR(data, parity bit) != 0.
- Odd mode: perr = XOR(data, parity bit) != 1.
REQ-019 In STOP, each stop bit sampled 0 SHALL set ferr. After the last stop bit the FSM SHALL go to COMMIT, and it SHALL sample no further stop bits once ferr is set.
REQ-020 COMMIT SHALL last one cycle and push {data, perr, ferr} into the FIFO. It SHALL then go to WAIT_IDLE if ferr = 1, otherwise to IDLE.
REQ-021 WAIT_IDLE SHALL return to IDLE only after 16 consecutive ticks with synchronised rxd = 1.
REQ-022 Break: when data = 0, the parity bit (if enabled) = 0 and ferr = 1, brk SHALL pulse during the COMMIT cycle; the word SHALL still be pushed with m_ferr = 1.
REQ-023 The FIFO SHALL be first-word-fall-through, with m_valid = not empty and m_data, m_perr and m_ferr reflecting the head entry. A pop SHALL occur when m_valid && m_ready.
REQ-024 m_data, m_perr and m_ferr SHALL hold stable while m_valid = 1 and m_ready = 0.
REQ-025 Push latency: m_valid SHALL rise on the cycle after COMMIT when the FIFO was empty.
REQ-026 When a push occurs on a full FIFO with no pop in the same cycle, the new word SHALL be dropped, overrun SHALL pulse, and the contents SHALL be unchanged.
REQ-027 When a push and a pop occur in the same cycle on a full FIFO, both SHALL complete with no overrun.
REQ-028 When a push and a pop occur in the same cycle on an empty FIFO, the push SHALL complete and the pop SHALL be ignored, since m_valid = 0.
REQ-029 The read and write pointers SHALL be clog2(FIFO_DEPTH)+1 bits wide, with wrap-around by natural overflow.
REQ-030 Changes to cfg_* mid-frame SHALL have no effect until the next START.

Reset
REQ-031 While rst_n = 0, the block SHALL immediately hold:
- state IDLE;
- accumulator 0;
- synchroniser flops 1;
- FIFO empty, with pointers 0;
- outputs: m_valid, m_data, m_perr, m_ferr, overrun, brk and busy all 0.
REQ-032 Reset asserted mid-frame SHALL abort the frame and flush the FIFO; after release the next valid frame SHALL be received correctly.

Verification
REQ-033 Nominal: cfg_inc = 1208 (115200 baud at 100 MHz), 8N1, byte 0xA5, m_ready = 1 -> one m_valid pulse with m_data = 0x0A5, m_perr = 0, m_ferr = 0.
REQ-034 Parity: 7O2, 0x35 sent with even-parity bit -> m_data = 0x035, m_perr = 1, m_ferr = 0; the same byte with the correct bit -> m_perr = 0.
REQ-035 Framing/break: 8N1, rxd held low for 12 bit times then high -> one word 0x000 with m_ferr = 1 and one brk pulse; busy stays high until 16 idle ticks have elapsed.
REQ-036 Glitch: rxd low for 4 ticks only -> no push, busy returns to 0, m_valid stays 0.
REQ-037 Overrun: m_ready = 0, FIFO_DEPTH + 1 frames 0x01..0x05 -> exactly one overrun pulse; draining then yields 0x01..0x04 in order.
REQ-038 Reset mid-frame: rst_n pulsed during DATA of 0x3C, then frame 0x5A sent -> m_valid 0 after reset, then a single word 0x05A.
